memory_game_engine: RTL and testbench

Parametrised sequence-memory ("Simon"-style) game core for the memory tester. It replaces the fixed single-digit level flow with a growing sequence. Each level appends one pseudo-random digit, replays the whole stored sequence on flash_num, then checks user entries digit by digit. It sits between the auth/level-select logic and the seven_seg display drivers.

---
 rtl/memory_game_engine.sv | 193 +++++++++++++++++++
 tb/tb_memory_game_engine.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_game_engine.sv
// Sequence-memory game core: grows a pseudo-random digit sequence, replays it, then checks user entries.
// Optional input timeout guarded by macro GAME_INPUT_TIMEOUT_EN.
module memory_game_engine #(
    parameter int          DIGIT_W        = 4,
    parameter int          DIGIT_MAX      = 10,
    parameter int          MAX_LEVEL      = 8,
    parameter int          FLASH_CYCLES   = 25000000,
    parameter int          GAP_CYCLES     = 12500000,
    parameter int          TIMEOUT_CYCLES = 250000000,
    parameter logic [15:0] LFSR_SEED      = 16'hACE1,
    localparam int         LW             = $clog2(MAX_LEVEL + 1)
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               start,
    input  logic               auth_bit,
    input  logic               log_out,
    input  logic               punch_button,
    input  logic [DIGIT_W-1:0] toggle_answer,
    output logic [DIGIT_W-1:0] flash_num,
    output logic               flash_valid,
    output logic [DIGIT_W-1:0] seg_in_ans,
    output logic [LW-1:0]      level_num,
    output logic [LW-1:0]      digit_idx,
    output logic               busy,
    output logic               win,
    output logic               loose
);

    localparam int FG_MAX  = (FLASH_CYCLES > GAP_CYCLES) ? FLASH_CYCLES : GAP_CYCLES;
    localparam int CNT_MAX = (FG_MAX > TIMEOUT_CYCLES) ? FG_MAX : TIMEOUT_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int AW      = (MAX_LEVEL > 1) ? $clog2(MAX_LEVEL) : 1;

    typedef enum logic [2:0] {
        IDLE, APPEND, FLASH, GAP, INPUT, CHECK, WIN, LOSE
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        lfsr_q;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [LW-1:0]      level_q, level_d;
    logic [LW-1:0]      idx_q, idx_d;
    logic [LW-1:0]      ptr_q, ptr_d;
    logic [DIGIT_W-1:0] ans_q, ans_d;
    logic               win_q, win_d;
    logic               loose_q, loose_d;
    logic               seq_we;
    logic               counting;
    logic [DIGIT_W-1:0] cand;
    logic [DIGIT_W-1:0] seq_q [MAX_LEVEL];

    // Fold the raw LFSR nibble into 0..DIGIT_MAX-1 with one conditional subtract.
    always_comb begin
        if ({1'b0, lfsr_q[DIGIT_W-1:0]} >= (DIGIT_W+1)'(DIGIT_MAX))
            cand = lfsr_q[DIGIT_W-1:0] - DIGIT_W'(DIGIT_MAX);
        else
            cand = lfsr_q[DIGIT_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        ans_d   = ans_q;
        win_d   = win_q;
        loose_d = loose_q;
        seq_we  = 1'b0;
        if (log_out || !auth_bit) begin
            state_d = IDLE;
            level_d = '0;
            idx_d   = '0;
            ptr_d   = '0;
            win_d   = 1'b0;
            loose_d = 1'b0;
        end else begin
            case (state_q)
                IDLE, WIN, LOSE: begin
                    if (start) begin
                        win_d   = 1'b0;
                        loose_d = 1'b0;
                        level_d = LW'(1);
                        idx_d   = '0;
                        state_d = APPEND;
                    end
                end
                APPEND: begin
                    seq_we  = 1'b1;
                    ptr_d   = '0;
                    state_d = FLASH;
                end
                FLASH: begin
                    if (cnt_q == CW'(FLASH_CYCLES - 1)) state_d = GAP;
                end
                GAP: begin
                    if (cnt_q == CW'(GAP_CYCLES - 1)) begin
                        ptr_d = ptr_q + LW'(1);
                        if (ptr_q + LW'(1) == level_q) begin
                            idx_d   = '0;
                            state_d = INPUT;
                        end else begin
                            state_d = FLASH;
                        end
                    end
                end
                INPUT: begin
                    if (punch_button) begin
                        ans_d   = toggle_answer;
                        state_d = CHECK;
                    end
`ifdef GAME_INPUT_TIMEOUT_EN
                    else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                        loose_d = 1'b1;
                        state_d = LOSE;
                    end
`endif
                end
                CHECK: begin
                    if (ans_q != seq_q[AW'(idx_q)]) begin
                        loose_d = 1'b1;
                        state_d = LOSE;
                    end else if (idx_q + LW'(1) < level_q) begin
                        idx_d   = idx_q + LW'(1);
                        state_d = INPUT;
                    end else if (level_q == LW'(MAX_LEVEL)) begin
                        win_d   = 1'b1;
                        state_d = WIN;
                    end else begin
                        level_d = level_q + LW'(1);
                        idx_d   = '0;
                        state_d = APPEND;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

`ifdef GAME_INPUT_TIMEOUT_EN
    assign counting = (state_q == FLASH) || (state_q == GAP) || (state_q == INPUT);
`else
    assign counting = (state_q == FLASH) || (state_q == GAP);
`endif

    // Clears on any state change (including re-entry via another state); saturates rather than wraps.
    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q)
            cnt_d = '0;
        else if (counting && (cnt_q != {CW{1'b1}}))
            cnt_d = cnt_q + CW'(1);
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            lfsr_q  <= LFSR_SEED;
            cnt_q   <= '0;
            level_q <= '0;
            idx_q   <= '0;
            ptr_q   <= '0;
            ans_q   <= '0;
            win_q   <= 1'b0;
            loose_q <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            ans_q   <= ans_d;
            win_q   <= win_d;
            loose_q <= loose_d;
        end
    end

    // Sequence storage needs no reset: every slot is written before it is read.
    always_ff @(posedge clock) begin
        if (seq_we) seq_q[AW'(level_q - LW'(1))] <= cand;
    end

    assign flash_valid = (state_q == FLASH);
    assign flash_num   = flash_valid ? seq_q[AW'(ptr_q)] : '0;
    assign seg_in_ans  = ans_q;
    assign level_num   = level_q;
    assign digit_idx   = idx_q;
    assign busy        = !((state_q == IDLE) || (state_q == WIN) || (state_q == LOSE));
    assign win         = win_q;
    assign loose       = loose_q;

endmodule

// File: tb/tb_memory_game_engine.sv
// Directed bench for memory_game_engine with short flash/gap timing and three levels.
module tb_memory_game_engine;

    localparam int MAX_LEVEL = 3;
    localparam int LW        = $clog2(MAX_LEVEL + 1);

    logic          clock = 1'b0;
    logic          rst   = 1'b1;
    logic          start = 1'b0;
    logic          auth_bit = 1'b0;
    logic          log_out = 1'b0;
    logic          punch_button = 1'b0;
    logic [3:0]    toggle_answer = '0;
    logic [3:0]    flash_num;
    logic          flash_valid;
    logic [3:0]    seg_in_ans;
    logic [LW-1:0] level_num;
    logic [LW-1:0] digit_idx;
    logic          busy;
    logic          win;
    logic          loose;

    int n_pass = 0;
    int n_chk  = 0;
    int dig [8];
    int first_digit;
    logic [3:0] wrong;

    memory_game_engine #(
        .DIGIT_W(4), .DIGIT_MAX(10), .MAX_LEVEL(MAX_LEVEL),
        .FLASH_CYCLES(4), .GAP_CYCLES(2), .TIMEOUT_CYCLES(20), .LFSR_SEED(16'hACE1)
    ) dut (
        .clock(clock), .rst(rst), .start(start), .auth_bit(auth_bit), .log_out(log_out),
        .punch_button(punch_button), .toggle_answer(toggle_answer),
        .flash_num(flash_num), .flash_valid(flash_valid), .seg_in_ans(seg_in_ans),
        .level_num(level_num), .digit_idx(digit_idx), .busy(busy), .win(win), .loose(loose)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Records len flashed digits, checks their timing, and returns in the first INPUT cycle.
    task automatic capture(input int len);
        int hi, lo, wt;
        for (int k = 0; k < len; k++) begin
            wt = 0;
            while (!flash_valid && wt < 100) begin tick(); wt++; end
            if (wt >= 100) begin
                check("flash_wait_timeout", 0, 1);
                return;
            end
            dig[k] = flash_num;
            check("digit_range", 32'(dig[k] < 10), 1);
            hi = 0;
            while (flash_valid && hi < 100) begin hi++; tick(); end
            check("flash_hi_cycles", hi, 4);
            if (k < len - 1) begin
                lo = 0;
                while (!flash_valid && lo < 100) begin lo++; tick(); end
                check("gap_lo_cycles", lo, 2);
            end
        end
        tick();
        tick();
    endtask

    task automatic punch(input logic [3:0] v);
        toggle_answer = v;
        punch_button  = 1'b1;
        tick();
        punch_button  = 1'b0;
        tick();
    endtask

    initial begin
        tick();
        check("rst_busy", busy, 0);
        check("rst_level", level_num, 0);
        check("rst_flash_valid", flash_valid, 0);
        check("rst_win_loose", {win, loose}, 0);
        rst = 1'b0;
        tick();

        // Start gating
        pulse_start();
        tick();
        check("start_noauth_busy", busy, 0);
        auth_bit = 1'b1;
        tick();
        pulse_start();
        check("start_level1", level_num, 1);
        check("start_busy", busy, 1);
        check("append_no_flash", flash_valid, 0);
        tick();
        check("flash_after_2clk", flash_valid, 1);

        // Full win: levels 1..3
        capture(1);
        first_digit = dig[0];
        check("input_idx0", digit_idx, 0);
        punch(4'(dig[0]));
        check("lvl2", level_num, 2);
        capture(2);
        check("prefix_kept", dig[0], first_digit);
        punch(4'(dig[0]));
        check("idx_adv", digit_idx, 1);
        punch(4'(dig[1]));
        check("lvl3", level_num, 3);
        capture(3);
        punch(4'(dig[0]));
        punch(4'(dig[1]));
        toggle_answer = 4'(dig[2]);
        punch_button  = 1'b1;
        tick();
        punch_button  = 1'b0;
        check("win_not_yet", win, 0);
        tick();
        check("win_set", win, 1);
        check("win_level", level_num, 3);
        check("win_loose", loose, 0);
        check("win_busy", busy, 0);
        tick();
        check("win_sticky", win, 1);

        // Wrong digit at level 2, index 1
        pulse_start();
        check("restart_win_clr", win, 0);
        check("restart_level", level_num, 1);
        capture(1);
        punch(4'(dig[0]));
        capture(2);
        punch(4'(dig[0]));
        wrong = 4'((dig[1] + 1) % 10);
        toggle_answer = wrong;
        punch_button  = 1'b1;
        tick();
        punch_button  = 1'b0;
        check("loose_not_yet", loose, 0);
        tick();
        check("loose_set", loose, 1);
        check("lose_win", win, 0);
        check("lose_level", level_num, 2);
        check("lose_echo", seg_in_ans, 32'(wrong));
        pulse_start();
        check("restart_loose_clr", loose, 0);
        check("restart_level2", level_num, 1);

        // Abort cases
        tick();
        toggle_answer = ~wrong;
        punch_button  = 1'b1;
        tick();
        punch_button  = 1'b0;
        check("punch_in_flash_ignored", seg_in_ans, 32'(wrong));
        log_out = 1'b1;
        tick();
        log_out = 1'b0;
        check("abort_flash_busy", busy, 0);
        check("abort_flash_level", level_num, 0);
        check("abort_flash_fv", flash_valid, 0);
        pulse_start();
        capture(1);
        toggle_answer = ~wrong;
        punch_button  = 1'b1;
        log_out       = 1'b1;
        tick();
        punch_button  = 1'b0;
        log_out       = 1'b0;
        check("abort_punch_busy", busy, 0);
        check("abort_punch_loose", loose, 0);
        check("abort_punch_level", level_num, 0);
        check("abort_punch_echo", seg_in_ans, 32'(wrong));
        pulse_start();
        capture(1);
        auth_bit = 1'b0;
        tick();
        check("deauth_busy", busy, 0);
        check("deauth_level", level_num, 0);
        check("deauth_loose", loose, 0);
        auth_bit = 1'b1;
        tick();

        // Asynchronous reset mid-flash
        pulse_start();
        tick();
        check("pre_rst_fv", flash_valid, 1);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_fv", flash_valid, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_level", level_num, 0);
        check("async_rst_echo", seg_in_ans, 0);
        #1;
        rst = 1'b0;
        tick();
        check("post_rst_idle", busy, 0);

`ifdef GAME_INPUT_TIMEOUT_EN
        pulse_start();
        capture(1);
        repeat (19) tick();
        check("to_not_yet", loose, 0);
        check("to_busy", busy, 1);
        tick();
        check("to_loose", loose, 1);
        pulse_start();
        capture(1);
        repeat (19) tick();
        toggle_answer = 4'(dig[0]);
        punch_button  = 1'b1;
        tick();
        punch_button  = 1'b0;
        tick();
        check("to_punch_wins_loose", loose, 0);
        check("to_punch_wins_level", level_num, 2);
`else
        pulse_start();
        capture(1);
        repeat (1000) tick();
        check("no_to_loose", loose, 0);
        check("no_to_busy", busy, 1);
`endif
        log_out = 1'b1;
        tick();
        log_out = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
